// File: rtl/video_stream_switch.sv
// AXI-Stream video input switch: frame-aligned channel selection into a
// first-word-fall-through output FIFO, with frame counting and a sticky error flag.
module video_stream_switch #(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 24,
  parameter int FIFO_DEPTH  = 16,
  parameter int DRAIN_UNSEL = 1
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH-1:0]        s_tvalid,
  input  logic [NUM_CH-1:0]        s_tuser,
  input  logic [NUM_CH-1:0]        s_tlast,
  output logic [NUM_CH-1:0]        s_tready,
  input  logic [1:0]               sel,
  input  logic                     err_clr,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tuser,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [1:0]               active_ch,
  output logic                     error,
  output logic [15:0]              frame_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SYNC, PASS} state_t;
  state_t state, state_nx;

  logic              a_valid, a_user, a_last;
  logic [DATA_W-1:0] a_data;
  logic              act_ready, unsel_ready, a_xfer, push, pop, full;
  logic              sel_ok, switch_req, sw_hold, chan_change, err_set;
  logic              last_seen_tlast, open_sof;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [EW-1:0]     head;

  always_comb begin
    a_valid = 1'b0;
    a_user  = 1'b0;
    a_last  = 1'b0;
    a_data  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(active_ch) == k) begin
        a_valid = s_tvalid[k];
        a_user  = s_tuser[k];
        a_last  = s_tlast[k];
        a_data  = s_tdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign sel_ok     = int'(sel) < NUM_CH;
  assign switch_req = sel_ok && (sel != active_ch);
  assign full       = (count == FULL_CNT);
  // An SOF on the active channel is the only point where a pending switch may take effect.
  assign sw_hold    = (state == PASS) && a_valid && a_user && switch_req;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = SYNC;
      SYNC:    if (push) state_nx = PASS;
      PASS:    if (sw_hold) state_nx = SYNC;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    act_ready   = 1'b0;
    push        = 1'b0;
    unsel_ready = (DRAIN_UNSEL != 0) && (state != IDLE);
    case (state)
      SYNC: begin
        act_ready = a_user ? (!full && !switch_req) : 1'b1;
        push      = a_valid && a_user && act_ready;
      end
      PASS: begin
        act_ready = !full && !sw_hold;
        push      = a_valid && act_ready;
      end
      default: ;
    endcase
    s_tready = '0;
    for (int k = 0; k < NUM_CH; k++)
      s_tready[k] = (int'(active_ch) == k) ? act_ready : unsel_ready;
  end

  assign a_xfer      = a_valid && act_ready;
  assign chan_change = (state == IDLE) || ((state == SYNC) && switch_req) || sw_hold;
  assign err_set     = a_xfer && a_user && (((state == PASS) && !last_seen_tlast) || open_sof);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      active_ch       <= 2'd0;
      last_seen_tlast <= 1'b1;
      open_sof        <= 1'b0;
      error           <= 1'b0;
      frame_cnt       <= 16'd0;
    end else begin
      if (state == IDLE)    active_ch <= sel_ok ? sel : 2'd0;
      else if (chan_change) active_ch <= sel;
      // Line-structure history restarts whenever the forwarded channel changes.
      if (chan_change) begin
        last_seen_tlast <= 1'b1;
        open_sof        <= 1'b0;
      end else if (a_xfer) begin
        last_seen_tlast <= a_last;
        open_sof        <= a_user && !a_last;
      end
      if (err_set)      error <= 1'b1;
      else if (err_clr) error <= 1'b0;
      if (push && a_user) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Output FIFO: pointers wrap naturally at the power-of-two depth.
  assign m_tvalid = (count != '0);
  assign pop      = m_tvalid && m_tready;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= {a_user, a_last, a_data};
  end

  assign head    = mem[rd_ptr];
  assign m_tdata = m_tvalid ? head[DATA_W-1:0] : '0;
  assign m_tuser = m_tvalid && head[EW-1];
  assign m_tlast = m_tvalid && head[EW-2];

endmodule
